// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, sync, display enable and start strobes.
// Optional frame counter output enabled by defining VTG_FRAME_COUNT_EN.
module video_timing_gen #(
    parameter int CW       = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
`ifdef VTG_FRAME_COUNT_EN
    ,
    output logic [7:0]    frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_STA  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_STA + H_SYNC;
    localparam int VS_STA  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_STA + V_SYNC;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_STA_C = CW'(HS_STA);
    localparam logic [CW-1:0] HS_END_C = CW'(HS_END);
    localparam logic [CW-1:0] VS_STA_C = CW'(VS_STA);
    localparam logic [CW-1:0] VS_END_C = CW'(VS_END);
    localparam logic [CW-1:0] ONE      = CW'(1);

    localparam logic HS_OFF = (H_POL == 0) ? 1'b1 : 1'b0;
    localparam logic VS_OFF = (V_POL == 0) ? 1'b1 : 1'b0;

    // Illegal timing is rejected at elaboration; nothing here reaches the netlist.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        (2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_param_check
        $error("video_timing_gen: illegal timing parameters");
    end

    logic          h_wrap;
    logic          v_wrap;
    logic [CW-1:0] sx_nxt;
    logic [CW-1:0] sy_nxt;

    always_comb begin
        h_wrap = (sx == H_LAST);
        v_wrap = h_wrap && (sy == V_LAST);
        sx_nxt = h_wrap ? '0 : sx + ONE;
        sy_nxt = sy;
        if (h_wrap) begin
            sy_nxt = v_wrap ? '0 : sy + ONE;
        end
    end

    // Decode uses the next counter values so every output lines up with sx/sy.
    always_ff @(posedge clk) begin
        if (reset) begin
            sx          <= '0;
            sy          <= '0;
            de          <= 1'b1;
            hsync       <= HS_OFF;
            vsync       <= VS_OFF;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                sx          <= sx_nxt;
                sy          <= sy_nxt;
                de          <= (sx_nxt < H_ACT_C) && (sy_nxt < V_ACT_C);
                hsync       <= ((sx_nxt >= HS_STA_C) && (sx_nxt < HS_END_C)) ? ~HS_OFF : HS_OFF;
                vsync       <= ((sy_nxt >= VS_STA_C) && (sy_nxt < VS_END_C)) ? ~VS_OFF : VS_OFF;
                line_start  <= h_wrap;
                frame_start <= v_wrap;
            end
        end
    end

`ifdef VTG_FRAME_COUNT_EN
    // Advances on the same edge that raises frame_start, so it is already updated while frame_start is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= 8'd0;
        end else if (pix_en && v_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two small timing configurations, an arithmetic raster model
// checked every cycle, and directed literal checks at hand-computed positions.
module tb_video_timing_gen;

    // Config A: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), active-low syncs
    localparam int A_HT = 8,  A_VT = 6,  A_HA = 4,  A_HSS = 5,  A_HSE = 7,  A_VA = 3, A_VSS = 4,  A_VSE = 5;
    // Config B: H 10/2/3/2 (total 17), V 6/2/2/2 (total 12), active-high syncs
    localparam int B_HT = 17, B_VT = 12, B_HA = 10, B_HSS = 12, B_HSE = 15, B_VA = 6, B_VSS = 8, B_VSE = 10;

    logic       clk;
    logic       reset;
    logic       pix_en;
    logic [3:0] sx_a, sy_a;
    logic       hsync_a, vsync_a, de_a, ls_a, fs_a;
    logic [4:0] sx_b, sy_b;
    logic       hsync_b, vsync_b, de_b, ls_b, fs_b;
`ifdef VTG_FRAME_COUNT_EN
    logic [7:0] fc_a, fc_b;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    video_timing_gen #(
        .CW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(0), .V_POL(0)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .sx(sx_a), .sy(sy_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
        .line_start(ls_a), .frame_start(fs_a)
`ifdef VTG_FRAME_COUNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    video_timing_gen #(
        .CW(5), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .H_POL(1), .V_POL(1)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .sx(sx_b), .sy(sy_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
        .line_start(ls_b), .frame_start(fs_b)
`ifdef VTG_FRAME_COUNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    // ---------------- model ----------------
    // p counts pixel ticks since reset; positions follow by division/modulo.
    int p         = 0;
    bit tick_last = 0;

    always @(posedge clk) begin
        if (reset) begin
            p         = 0;
            tick_last = 0;
        end else if (pix_en) begin
            p         = p + 1;
            tick_last = 1;
        end else begin
            tick_last = 0;
        end
    end

    task automatic check1(input string what, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", what, got, exp, $time);
        end
    endtask

    task automatic check_cfg(input string tag, input int ht, vt, ha, hss, hse, va, vss, vse, pol,
                             input int g_sx, g_sy, g_hs, g_vs, g_de, g_ls, g_fs, g_fc);
        int ex, ey, ls;
        ex = p % ht;
        ey = (p / ht) % vt;
        ls = (tick_last && ex == 0) ? 1 : 0;
        check1({tag, "_sx"}, g_sx, ex);
        check1({tag, "_sy"}, g_sy, ey);
        check1({tag, "_hsync"}, g_hs, (ex >= hss && ex < hse) ? pol : 1 - pol);
        check1({tag, "_vsync"}, g_vs, (ey >= vss && ey < vse) ? pol : 1 - pol);
        check1({tag, "_de"}, g_de, (ex < ha && ey < va) ? 1 : 0);
        check1({tag, "_line_start"}, g_ls, ls);
        check1({tag, "_frame_start"}, g_fs, (ls == 1 && ey == 0) ? 1 : 0);
`ifdef VTG_FRAME_COUNT_EN
        check1({tag, "_frame_cnt"}, g_fc, (p / (ht * vt)) % 256);
`endif
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            int fca, fcb;
            fca = 0;
            fcb = 0;
`ifdef VTG_FRAME_COUNT_EN
            fca = int'(fc_a);
            fcb = int'(fc_b);
`endif
            check_cfg("a", A_HT, A_VT, A_HA, A_HSS, A_HSE, A_VA, A_VSS, A_VSE, 0,
                      int'(sx_a), int'(sy_a), int'(hsync_a), int'(vsync_a), int'(de_a),
                      int'(ls_a), int'(fs_a), fca);
            check_cfg("b", B_HT, B_VT, B_HA, B_HSS, B_HSE, B_VA, B_VSS, B_VSE, 1,
                      int'(sx_b), int'(sy_b), int'(hsync_b), int'(vsync_b), int'(de_b),
                      int'(ls_b), int'(fs_b), fcb);
        end
    end

    // ---------------- driver tasks (start and end on a falling edge) ----------------
    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) begin
            pix_en = 1'b1;
            @(negedge clk);
        end
        pix_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            pix_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        reset  = 1'b1;
        pix_en = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        pix_en = 1'b0;
    endtask

    // Alternating enable: the gap between line_start pulses of config A is two lines of clk.
    task automatic toggle_gap();
        int first, second;
        first  = -1;
        second = -1;
        for (int cyc = 0; cyc < 200 && second < 0; cyc++) begin
            pix_en = (cyc % 2 == 0);
            @(negedge clk);
            if (ls_a) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        pix_en = 1'b0;
        check1("ls_gap_toggle", second - first, 2 * A_HT);
    endtask

    task automatic count_de(input int n, output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 0; i < n; i++) begin
            pix_en = 1'b1;
            @(negedge clk);
            if (de_a) ca++;
            if (de_b) cb++;
        end
        pix_en = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ca, cb;
        reset  = 1'b1;
        pix_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        chk_on = 1;

        check1("rst_sx_a", int'(sx_a), 0);
        check1("rst_sy_a", int'(sy_a), 0);
        check1("rst_de_a", int'(de_a), 1);
        check1("rst_hsync_a", int'(hsync_a), 1);
        check1("rst_vsync_a", int'(vsync_a), 1);
        check1("rst_hsync_b", int'(hsync_b), 0);
        check1("rst_vsync_b", int'(vsync_b), 0);
        check1("rst_strobes", int'(ls_a) + int'(fs_a) + int'(ls_b) + int'(fs_b), 0);

        run_en(13);
        check1("t13_sx_a", int'(sx_a), 5);
        check1("t13_sy_a", int'(sy_a), 1);
        check1("t13_hsync_a", int'(hsync_a), 0);
        check1("t13_de_a", int'(de_a), 0);

        idle(5);
        check1("hold_sx_a", int'(sx_a), 5);
        check1("hold_sy_a", int'(sy_a), 1);

        run_en(34);
        check1("t47_sx_a", int'(sx_a), 7);
        check1("t47_sy_a", int'(sy_a), 5);
        check1("t47_fs_a", int'(fs_a), 0);

        run_en(1);
        check1("t48_sx_a", int'(sx_a), 0);
        check1("t48_sy_a", int'(sy_a), 0);
        check1("t48_fs_a", int'(fs_a), 1);
        check1("t48_ls_a", int'(ls_a), 1);
        check1("t48_sx_b", int'(sx_b), 14);
        check1("t48_sy_b", int'(sy_b), 2);
        check1("t48_hsync_b", int'(hsync_b), 1);

        idle(1);
        check1("strobe_1clk_fs_a", int'(fs_a), 0);
        check1("strobe_1clk_ls_a", int'(ls_a), 0);

        toggle_gap();

        count_de(A_HT * A_VT, ca, cb);
        check1("de_per_frame_a", ca, A_HA * A_VA);
        count_de(B_HT * B_VT, ca, cb);
        check1("de_per_frame_b", cb, B_HA * B_VA);

        run_en(500);
        idle(3);
        run_en(37);

        pulse_reset();
        check1("mid_rst_sx_a", int'(sx_a), 0);
        check1("mid_rst_sy_a", int'(sy_a), 0);
        check1("mid_rst_de_b", int'(de_b), 1);
        check1("mid_rst_strobes", int'(ls_a) + int'(fs_a) + int'(ls_b) + int'(fs_b), 0);

        run_en(9);
        check1("resume_sx_a", int'(sx_a), 1);
        check1("resume_sy_a", int'(sy_a), 1);

`ifdef VTG_FRAME_COUNT_EN
        pulse_reset();
        run_en(260 * A_HT * A_VT);
        check1("fc_a_260_frames", int'(fc_a), 4);
`endif

        run_en(100);
        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator for the pong video path. It produces pixel and line coordinates, sync pulses, a display-enable signal and line/frame start strobes. All timing comes from per-porch parameters, and sync polarity is configurable. A pixel clock-enable lets the block run from a faster system clk. All outputs are registered and aligned to the same clk edge as the coordinates.

Parameters:
CW, 10, width of sx/sy counters; must hold H_TOTAL-1 and V_TOTAL-1
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active-low, 1 = active-high)
V_POL, 0, vsync asserted level (0 = active-low, 1 = active-high)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset; clock is clk
pix_en  input  1  pixel clock enable; counters advance only on clk edges where pix_en=1
sx  output  CW  current pixel column, 0..H_TOTAL-1
sy  output  CW  current line, 0..V_TOTAL-1
hsync  output  1  horizontal sync at H_POL level while asserted
vsync  output  1  vertical sync at V_POL level while asserted
de  output  1  high when sx<H_ACTIVE and sy<V_ACTIVE
line_start  output  1  one-clk pulse on the edge where sx becomes 0
frame_start  output  1  one-clk pulse on the edge where sx and sy both become 0

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
  - HS_STA = H_ACTIVE+H_FP, HS_END = HS_STA+H_SYNC
  - VS_STA = V_ACTIVE+V_FP, VS_END = VS_STA+V_SYNC
- Parameter legality:
  - All porch and sync parameters must be >=1.
  - 2^CW must be >= max(H_TOTAL, V_TOTAL).
  - Violations are caught by an elaboration-time check in simulation. Not synthesised.
- Reset (overrides pix_en):
  - sx=0, sy=0, de=1
  - hsync=~H_POL, vsync=~V_POL (deasserted)
  - line_start=0, frame_start=0
  - Reset mid-frame returns to this state on the next edge. No strobe is emitted for the reset-induced return to 0,0.
- Counting, on each clk edge with pix_en=1:
  - sx==H_TOTAL-1: sx<=0, and sy<=(sy==V_TOTAL-1)?0:sy+1.
  - Otherwise: sx<=sx+1, sy unchanged.
- pix_en=0: sx, sy, de, hsync and vsync hold; line_start and frame_start are 0.
- Registered decode, computed from the next counter values so that all outputs refer to the same (sx,sy) in the same cycle. There is no extra pipeline latency relative to sx/sy.
  - hsync asserted iff HS_STA<=sx<HS_END
  - vsync asserted iff VS_STA<=sy<VS_END
  - de iff sx<H_ACTIVE and sy<V_ACTIVE
- Strobes:
  - line_start=1 for exactly one clk cycle following a wrap of sx to 0 under pix_en.
  - frame_start=1 on the same cycle when that wrap also takes sy to 0.
  - A strobe is never longer than one clk, even if pix_en stays low afterwards.
- Arithmetic: counters are unsigned CW bits and never exceed H_TOTAL-1 / V_TOTAL-1. All comparisons are against CW-bit constants.

Optional Feature:
Macro VTG_FRAME_COUNT_EN.
- Defined:
  - Adds output frame_cnt [7:0].
  - Reset value 0.
  - Increments by 1 (mod 256) on each cycle where frame_start=1.
  - Wraps 255->0 with no flag.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
1. Defaults, pix_en=1 constantly, 2 frames -> line period 800 clk; hsync=0 for sx 656..751; vsync=0 for sy 490..491; de high 640 clk per active line; frame_start every 420000 clk.
2. pix_en toggling 1,0,1,0 -> line_start spacing 1600 clk with each pulse 1 clk wide; outputs hold during pix_en=0.
3. H_POL=1, V_POL=1 -> hsync=1 only for sx 656..751; vsync=1 only for sy 490..491; both 0 after reset.
4. Tiny timing (H 4/1/2/1, V 3/1/1/1, CW=4), pix_en=1 -> sx cycles 0..7; sy cycles 0..5; frame_start every 48 clk; de pattern matches 4x3 active window.
5. Reset asserted at sx=300, sy=200 for 1 clk -> next cycle sx=0, sy=0, de=1, syncs deasserted, no strobe; counting resumes normally.
6. VTG_FRAME_COUNT_EN defined, tiny timing, 260 frames -> frame_cnt reaches 255 then 0, then 4 at end.
